// File: rtl/status_flag_unit.sv
// Execute-stage ALU with the NZCV status register feeding the decode-stage condition checker.
// Optional STATUS_BYPASS_EN forwards the flags being written this cycle straight to the status bus.
module status_flag_unit #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              valid,
   input  logic              s_bit,
   input  logic              cond_pass,
   input  logic [3:0]        exe_cmd,
   input  logic [DATA_W-1:0] val1,
   input  logic [DATA_W-1:0] val2,
   output logic [DATA_W-1:0] alu_result,
   output logic [3:0]        status_register_bits,
   output logic              flags_pending
);

   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;
   localparam logic [3:0] CMD_MVN = 4'b1001;

   logic [3:0]        flag_reg;
   logic [3:0]        new_flags;
   logic [DATA_W:0]   add_sum;
   logic [DATA_W:0]   sub_sum;
   logic              add_cin;
   logic              sub_cin;
   logic              listed;
   logic              is_add;
   logic              is_sub;
   logic              update_now;
   logic              msb_a;
   logic              msb_b;
   logic              msb_r;

   // Carry-in always comes from the committed register, never the forward path.
   always_comb begin
      add_cin = (exe_cmd == CMD_ADC) ? flag_reg[1] : 1'b0;
      sub_cin = (exe_cmd == CMD_SBC) ? flag_reg[1] : 1'b1;
   end

   // Subtraction as a + ~b + cin, so the carry out is the ARM not-borrow.
   assign add_sum = {1'b0, val1} + {1'b0, val2}  + {{DATA_W{1'b0}}, add_cin};
   assign sub_sum = {1'b0, val1} + {1'b0, ~val2} + {{DATA_W{1'b0}}, sub_cin};

   always_comb begin
      alu_result = '0;
      listed     = 1'b1;
      is_add     = 1'b0;
      is_sub     = 1'b0;
      case (exe_cmd)
         CMD_MOV: alu_result = val2;
         CMD_MVN: alu_result = ~val2;
         CMD_ADD, CMD_ADC: begin
            alu_result = add_sum[DATA_W-1:0];
            is_add     = 1'b1;
         end
         CMD_SUB, CMD_SBC: begin
            alu_result = sub_sum[DATA_W-1:0];
            is_sub     = 1'b1;
         end
         CMD_AND: alu_result = val1 & val2;
         CMD_ORR: alu_result = val1 | val2;
         CMD_EOR: alu_result = val1 ^ val2;
         default: listed = 1'b0;
      endcase
   end

   assign msb_a = val1[DATA_W-1];
   assign msb_b = val2[DATA_W-1];
   assign msb_r = alu_result[DATA_W-1];

   always_comb begin
      new_flags[3] = msb_r;
      new_flags[2] = (alu_result == '0);
      new_flags[1] = flag_reg[1];
      new_flags[0] = flag_reg[0];
      if (is_add) begin
         new_flags[1] = add_sum[DATA_W];
         new_flags[0] = (msb_a == msb_b) && (msb_r != msb_a);
      end else if (is_sub) begin
         new_flags[1] = sub_sum[DATA_W];
         new_flags[0] = (msb_a != msb_b) && (msb_r != msb_a);
      end
   end

   // Reset is folded in so neither the hazard line nor the forward path fires during reset.
   assign update_now = valid & s_bit & cond_pass & ~freeze & listed & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         flag_reg <= 4'b0000;
      end else if (update_now) begin
         flag_reg <= new_flags;
      end
   end

`ifdef STATUS_BYPASS_EN
   assign status_register_bits = update_now ? new_flags : flag_reg;
   assign flags_pending        = 1'b0;
`else
   assign status_register_bits = flag_reg;
   assign flags_pending        = update_now;
`endif

endmodule

// File: tb/tb_status_flag_unit.sv
// Randomized bench for status_flag_unit against an arithmetic reference model of the ALU and NZCV rules.
module tb_status_flag_unit;

   localparam int    W   = 32;
   localparam longint LIM = longint'(1) << (W - 1);
`ifdef STATUS_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         freeze;
   logic         valid;
   logic         s_bit;
   logic         cond_pass;
   logic [3:0]   exe_cmd;
   logic [W-1:0] val1;
   logic [W-1:0] val2;
   logic [W-1:0] alu_result;
   logic [3:0]   status_register_bits;
   logic         flags_pending;

   int           tests_run    = 0;
   int           tests_failed = 0;
   logic [W+4:0] exp_q[$];
   logic [3:0]   m_flags;
   logic [3:0]   m_new;
   bit           m_upd;

   // clock / reset
   always #5 clk = ~clk;

   status_flag_unit #(.DATA_W(W)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .freeze               (freeze),
      .valid                (valid),
      .s_bit                (s_bit),
      .cond_pass            (cond_pass),
      .exe_cmd              (exe_cmd),
      .val1                 (val1),
      .val2                 (val2),
      .alu_result           (alu_result),
      .status_register_bits (status_register_bits),
      .flags_pending        (flags_pending)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: wide integer arithmetic; carry/overflow from range tests on the exact result.
   function automatic void model_alu(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [3:0] f, output logic [W-1:0] r,
                                     output logic [3:0] nf, output bit lst);
      longint ua, ub, sa, sb, full, sfull, cin;
      bit     add_op, sub_op, c, v;
      ua = a; ub = b;
      sa = $signed(a); sb = $signed(b);
      cin = f[1] ? 1 : 0;
      lst = 1'b1; add_op = 1'b0; sub_op = 1'b0;
      full = 0; sfull = 0;
      c = f[1]; v = f[0];
      case (cmd)
         4'd1: full = ub;
         4'd9: full = ~ub;
         4'd2: begin full = ua + ub;             sfull = sa + sb;             add_op = 1'b1; end
         4'd3: begin full = ua + ub + cin;       sfull = sa + sb + cin;       add_op = 1'b1; end
         4'd4: begin full = ua - ub;             sfull = sa - sb;             sub_op = 1'b1; end
         4'd5: begin full = ua - ub - (1 - cin); sfull = sa - sb - (1 - cin); sub_op = 1'b1; end
         4'd6: full = ua & ub;
         4'd7: full = ua | ub;
         4'd8: full = ua ^ ub;
         default: begin full = 0; lst = 1'b0; end
      endcase
      r = full[W-1:0];
      if (add_op) c = (full >= (longint'(1) << W));
      if (sub_op) c = (full >= 0);
      if (add_op || sub_op) v = (sfull > LIM - 1) || (sfull < -LIM);
      nf = {r[W-1], (r == '0), c, v};
   endfunction

   // driver: apply inputs at negedge, score outputs 1 time unit later
   task automatic drive(input string tag, input bit r, input bit fz, input bit v, input bit s, input bit cp,
                        input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] er;
      logic [3:0]   nf;
      bit           lst;
      logic [W+4:0] e;
      @(negedge clk);
      rst = r; freeze = fz; valid = v; s_bit = s; cond_pass = cp;
      exe_cmd = cmd; val1 = a; val2 = b;
      model_alu(cmd, a, b, m_flags, er, nf, lst);
      m_upd = v && s && cp && !fz && lst && !r;
      m_new = nf;
      exp_q.push_back({er, (BYPASS && m_upd) ? nf : m_flags, BYPASS ? 1'b0 : m_upd});
      #1;
      e = exp_q.pop_front();
      check({tag, "_res"},  alu_result,           e[W+4:5]);
      check({tag, "_bits"}, status_register_bits, e[4:1]);
      check({tag, "_pend"}, flags_pending,        e[0]);
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) m_flags = 4'b0000;
      else if (m_upd) m_flags = m_new;
   endtask

   task automatic step(input string tag, input bit r, input bit fz, input bit v, input bit s, input bit cp,
                       input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b);
      drive(tag, r, fz, v, s, cp, cmd, a, b);
      tick();
   endtask

   task automatic idle_expect(input string tag, input logic [3:0] exp_bits);
      drive(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, '0, '0);
      check({tag, "_const"}, status_register_bits, exp_bits);
      tick();
   endtask

   function automatic logic [W-1:0] rand_val();
      case ($urandom_range(0, 5))
         0: rand_val = '0;
         1: rand_val = '1;
         2: rand_val = {1'b1, {(W-1){1'b0}}};
         3: rand_val = {1'b0, {(W-1){1'b1}}};
         4: rand_val = W'($urandom_range(0, 3));
         default: rand_val = $urandom;
      endcase
   endfunction

   initial begin
      rst = 1'b1; freeze = 1'b0; valid = 1'b1; s_bit = 1'b1; cond_pass = 1'b1;
      exe_cmd = 4'd2; val1 = 1; val2 = 1;
      m_flags = 4'b0000; m_upd = 1'b0; m_new = 4'b0000;
      @(posedge clk);

      // reset held two cycles with a flag-setting ADD present
      step("t1a", 1, 0, 1, 1, 1, 4'd2, 1, 1);
      step("t1b", 1, 0, 1, 1, 1, 4'd2, 1, 1);

      drive("t2", 0, 0, 1, 1, 1, 4'd4, 5, 5);
      check("t2_res_const", alu_result, 0);
      tick();
      idle_expect("t2_after", 4'b0110);

      drive("t3a", 0, 0, 1, 1, 1, 4'd2, 32'h7FFF_FFFF, 32'h1);
      check("t3a_res_const", alu_result, 32'h8000_0000);
      tick();
      idle_expect("t3a_after", 4'b1001);
      drive("t3b", 0, 0, 1, 1, 1, 4'd2, 32'hFFFF_FFFF, 32'h1);
      check("t3b_res_const", alu_result, 0);
      tick();
      idle_expect("t3b_after", 4'b0110);

      drive("t4_adc", 0, 0, 1, 1, 1, 4'd3, 1, 1);
      check("t4_adc_res_const", alu_result, 3);
      tick();
      idle_expect("t4_adc_after", 4'b0000);
      step("t4_nos", 0, 0, 1, 0, 1, 4'd2, 32'h7FFF_FFFF, 1);
      idle_expect("t4_nos_after", 4'b0000);
      step("t4_ncp", 0, 0, 1, 1, 0, 4'd4, 0, 1);
      idle_expect("t4_ncp_after", 4'b0000);
      step("t4_and", 0, 0, 1, 1, 1, 4'd6, 32'hF0, 32'h0F);
      idle_expect("t4_and_after", 4'b0100);
      step("t4_ovf", 0, 0, 1, 1, 1, 4'd2, 32'h8000_0000, 32'h8000_0000);
      idle_expect("t4_ovf_after", 4'b0111);
      step("t4_mov", 0, 0, 1, 1, 1, 4'd1, 0, 32'h8000_0000);
      idle_expect("t4_mov_after", 4'b1011);
      step("t4_and2", 0, 0, 1, 1, 1, 4'd6, 32'hF0, 32'h0F);
      idle_expect("t4_and2_after", 4'b0111);

      for (int i = 0; i < 3; i++) begin
         drive("t5_frz", 0, 1, 1, 1, 1, 4'd4, 0, 1);
         check("t5_frz_hold", status_register_bits, 4'b0111);
         tick();
      end
      step("t5_rel", 0, 0, 1, 1, 1, 4'd4, 0, 1);
      idle_expect("t5_after", 4'b1000);

      drive("t6", 0, 0, 1, 1, 1, 4'd4, 3, 3);
      check("t6_bits_const", status_register_bits, BYPASS ? 4'b0110 : 4'b1000);
      check("t6_pend_const", flags_pending, BYPASS ? 1'b0 : 1'b1);
      tick();
      idle_expect("t6_after", 4'b0110);

      // reset coinciding with a flag write
      step("t7", 0, 0, 1, 1, 1, 4'd4, 0, 1);
      step("t7_rst", 1, 0, 1, 1, 1, 4'd4, 0, 1);
      idle_expect("t7_after", 4'b0000);

      for (int i = 0; i < 400; i++) begin
         step("rnd", $urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
              4'($urandom_range(0, 15)), rand_val(), rand_val());
      end

      check("exp_q_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
